// File: rtl/win_shift_buf.sv
// win_shift_buf: shifts K_H-tall pixel columns into a K_H x K_W window over an IMG_W-column band,
// emitting every STRIDE-th window on a valid/ready handshake and self-clearing at band end.
module win_shift_buf #(
  parameter int DW = 8,
  parameter int K_H = 3,
  parameter int K_W = 3,
  parameter int STRIDE = 1,
  parameter int IMG_W = 16,
  localparam int CW = $clog2(IMG_W + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [K_H-1:0][DW-1:0]           in_data,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [K_H-1:0][K_W-1:0][DW-1:0]  window,
  output logic [CW-1:0]                    win_col,
  output logic                             band_done
);
  localparam int SW = $clog2(STRIDE + 1);
  typedef enum logic [1:0] {S_FILL, S_WIN, S_SKIP, S_DONE} state_t;
  state_t state_q, state_d;
  logic [K_H-1:0][K_W-1:0][DW-1:0] win_q, win_d, win_sh;
  logic [CW-1:0] col_q, col_d, col_inc;
  logic [SW-1:0] skip_q, skip_d, skip_inc;
  logic acc;
  assign win_valid = state_q == S_WIN;
  assign band_done = state_q == S_DONE;
  // a held window blocks input so its contents never shift under the consumer
  assign in_ready = state_q == S_FILL || state_q == S_SKIP ||
                    (win_valid && win_ready && col_q < CW'(IMG_W));
  assign acc = in_valid && in_ready;
  assign col_inc = col_q + CW'(1);
  assign skip_inc = skip_q + SW'(1);
  assign window = win_q;
  assign win_col = col_q - CW'(K_W);
  always_comb begin
    for (int i = 0; i < K_H; i++) begin
      win_sh[i][0] = in_data[i];
      for (int j = 1; j < K_W; j++) win_sh[i][j] = win_q[i][j-1];
    end
  end
  always_comb begin
    state_d = state_q;
    col_d = acc ? col_inc : col_q;
    skip_d = skip_q;
    win_d = acc ? win_sh : win_q;
    case (state_q)
      S_FILL: state_d = acc && col_inc == CW'(K_W) ? S_WIN : S_FILL;
      S_WIN: if (win_ready) begin
        if (col_q == CW'(IMG_W)) state_d = S_DONE;
        else if (acc) begin
          skip_d = SW'(1);
          state_d = STRIDE == 1 ? S_WIN : col_inc == CW'(IMG_W) ? S_DONE : S_SKIP;
        end else begin
          skip_d = '0;
          state_d = S_SKIP;
        end
      end
      S_SKIP: if (acc) begin
        skip_d = skip_inc;
        state_d = skip_inc == SW'(STRIDE) ? S_WIN : col_inc == CW'(IMG_W) ? S_DONE : S_SKIP;
      end
      default: begin
        state_d = S_FILL;
        col_d = '0;
        skip_d = '0;
        win_d = '0;
      end
    endcase
    if (clear) begin
      state_d = S_FILL;
      col_d = '0;
      skip_d = '0;
      win_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      col_q <= '0;
      skip_q <= '0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      skip_q <= skip_d;
      win_q <= win_d;
    end
  end
endmodule
